// File: rtl/uart_sched_pkg.sv
// Shared types and header formatting for the UART TX burst scheduler.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD,
        CAP,
        DATA
    } state_t;

    localparam int HDR_CH_W  = 2;
    localparam int HDR_LEN_W = 6;

    // Header byte carries the channel id and the payload length minus one.
    function automatic logic [7:0] make_hdr(input logic [HDR_CH_W-1:0] ch,
                                            input logic [HDR_LEN_W:0]  len);
        logic [HDR_LEN_W:0] len_m1;
        len_m1 = len - 1'b1;
        return {ch, len_m1[HDR_LEN_W-1:0]};
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte stream from the scheduler to the UART transmitter adapter.
// Handshake: a byte moves on a CLK edge where TX_VALID && TX_READY; once
// TX_VALID is raised, it and TX_DATA hold until that edge.
interface uart_tx_sched_if;
    logic       TX_VALID;
    logic       TX_READY;
    logic [7:0] TX_DATA;

    modport master (output TX_VALID, output TX_DATA, input TX_READY);
    modport slave  (input TX_VALID, input TX_DATA, output TX_READY);
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational rotating-priority picker: the first requester at or above
// base (wrapping) wins.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        base,
    output logic [1:0]        grant,
    output logic              grant_valid
);

    logic [1:0] idx;

    // Walk from the lowest priority to the highest so the last hit wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = 2'((int'(base) + k) % NUM_CH);
            if (req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler muxing NUM_CH TX FIFOs onto one UART byte stream,
// one header byte plus up to BURST_MAX payload bytes per grant.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int BURST_MAX = 16,
    parameter int LVL_W     = 8
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic [NUM_CH-1:0]       CH_EN,
    input  logic [NUM_CH-1:0]       FIFO_EMPTY,
    input  logic [NUM_CH*LVL_W-1:0] FIFO_LEVEL,
    input  logic [NUM_CH*8-1:0]     FIFO_DIN,
    output logic [NUM_CH-1:0]       FIFO_RDEN,
    uart_tx_sched_if.master         tx,
    output logic                    BUSY,
    output logic [1:0]              GRANT_CH,
    output state_t                  dbg_state
);

    localparam int CNT_W = HDR_LEN_W + 1;

    state_t             state;
    logic [1:0]         rr_last;
    logic [CNT_W-1:0]   remaining;
    logic [NUM_CH-1:0]  eligible;
    logic [1:0]         rr_base;
    logic [1:0]         win_ch;
    logic               win_valid;
    logic [LVL_W-1:0]   win_level;
    logic [CNT_W-1:0]   win_len;
    logic [7:0]         sel_din;
    logic               rd_ok;
    logic               accept;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
        assign eligible[i] = CH_EN[i] && !FIFO_EMPTY[i] &&
                             (FIFO_LEVEL[i*LVL_W +: LVL_W] != '0);
    end

    assign rr_base   = (rr_last == 2'(NUM_CH - 1)) ? 2'd0 : rr_last + 2'd1;
    assign win_level = FIFO_LEVEL[int'(win_ch)*LVL_W +: LVL_W];
    assign win_len   = (32'(win_level) > BURST_MAX) ? CNT_W'(BURST_MAX)
                                                    : CNT_W'(win_level);
    assign sel_din   = FIFO_DIN[int'(GRANT_CH)*8 +: 8];
    assign rd_ok     = !FIFO_EMPTY[GRANT_CH];
    assign accept    = tx.TX_VALID && tx.TX_READY;
    assign BUSY      = (state != IDLE);
    assign dbg_state = state;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req         (eligible),
        .base        (rr_base),
        .grant       (win_ch),
        .grant_valid (win_valid)
    );

    // Read strobe is gated by the live empty flag so an empty FIFO just stalls RD.
    always_comb begin
        FIFO_RDEN = '0;
        if (state == RD && rd_ok) begin
            FIFO_RDEN[GRANT_CH] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state       <= IDLE;
            tx.TX_VALID <= 1'b0;
            tx.TX_DATA  <= '0;
            GRANT_CH    <= '0;
            rr_last     <= 2'(NUM_CH - 1);
            remaining   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        GRANT_CH    <= win_ch;
                        remaining   <= win_len;
                        tx.TX_DATA  <= make_hdr(win_ch, win_len);
                        tx.TX_VALID <= 1'b1;
                        state       <= HDR;
                    end
                end
                HDR: begin
                    if (accept) begin
                        tx.TX_VALID <= 1'b0;
                        state       <= RD;
                    end
                end
                RD: begin
                    if (rd_ok) begin
                        state <= CAP;
                    end
                end
                CAP: begin
                    tx.TX_DATA  <= sel_din;
                    tx.TX_VALID <= 1'b1;
                    state       <= DATA;
                end
                DATA: begin
                    if (accept) begin
                        tx.TX_VALID <= 1'b0;
                        remaining   <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            rr_last <= GRANT_CH;
                            state   <= IDLE;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one 8N1 UART transmit byte stream between NUM_CH independent transmit FIFOs.
- Each grant emits a framed burst: one header byte (channel id plus length), then up to BURST_MAX payload bytes read from the granted FIFO.
- Sits between the per-channel dual-clock TX FIFOs and the UART transmitter's valid/ready adapter.
- Lets several host-side streams be multiplexed over one physical TX pin.

Parameters:
- NUM_CH, 4, number of requesting FIFOs; legal 2..4 because the header channel field is fixed at 2 bits.
- BURST_MAX, 16, maximum payload bytes per grant; legal 1..64.
- LVL_W, 8, width of each FIFO fill-level input.

Ports:
- CLK  in  1  clock
- RESETn  in  1  synchronous active-low reset
- CH_EN  in  NUM_CH  per-channel enable mask
- FIFO_EMPTY  in  NUM_CH  per-channel empty flag
- FIFO_LEVEL  in  NUM_CH*LVL_W  per-channel fill level; channel i occupies [i*LVL_W +: LVL_W]
- FIFO_DIN  in  NUM_CH*8  per-channel read data; channel i occupies [i*8 +: 8]; valid the cycle after RDEN
- FIFO_RDEN  out  NUM_CH  one-hot read strobe
- TX_VALID  out  1  byte available to transmitter
- TX_READY  in  1  transmitter accepts the byte
- TX_DATA  out  8  byte to transmit
- BUSY  out  1  high when the FSM is not IDLE
- GRANT_CH  out  2  currently or last granted channel

Behaviour:
- Reset (RESETn low at a CLK edge):
  - state=IDLE; TX_VALID=0, TX_DATA=0, FIFO_RDEN=0, BUSY=0, GRANT_CH=0.
  - Round-robin pointer set so channel 0 has highest priority.
  - Remaining count cleared.
  - Reset mid-burst truncates the frame. No recovery byte is sent.
- Eligibility: channel i is eligible when CH_EN[i] && !FIFO_EMPTY[i] && FIFO_LEVEL[i]!=0.
- Arbitration (IDLE only):
  - Search order is (last grant+1) mod NUM_CH upward, wrapping; the first eligible channel wins.
  - On a win: GRANT_CH <= winner; len = min(FIFO_LEVEL, BURST_MAX), latched; state <= HDR.
  - No eligible channel: stay IDLE.
- HDR:
  - TX_VALID=1, TX_DATA={GRANT_CH[1:0], len-1[5:0]}.
  - Held stable until TX_VALID&&TX_READY, then state <= RD.
- RD: FIFO_RDEN[GRANT_CH]=1 for exactly one cycle if !FIFO_EMPTY[GRANT_CH], then state <= CAP. If empty, stay in RD with RDEN=0 (stall; frame integrity preserved).
- CAP: register FIFO_DIN[GRANT_CH]; state <= DATA.
- DATA:
  - TX_VALID=1, TX_DATA=captured byte, held until accepted.
  - On accept: remaining <= remaining-1.
  - If remaining was 1: state <= IDLE and GRANT_CH becomes the new round-robin base. Otherwise state <= RD.
- Latency:
  - Eligible seen in IDLE at cycle N -> header TX_VALID at N+1.
  - Header or byte accepted at cycle M -> RDEN at M+1 -> next byte TX_VALID at M+3.
  - After the last byte is accepted, IDLE can arbitrate on the following cycle.
- Level or CH_EN changes during a burst are ignored; len is latched at grant. Clearing CH_EN does not abort a burst.
- TX_VALID must never drop, and TX_DATA must never change, while TX_READY is low.
- FIFO_RDEN is at most one-hot and is asserted only in RD.
- TX_READY high outside HDR and DATA is ignored.

Decomposition:
- Package uart_sched_pkg contains:
  - state enum {IDLE, HDR, RD, CAP, DATA}
  - header field widths (CH 2, LEN 6)
  - function make_hdr(ch, len)
- Sub-module rr_arbiter: combinational rotating-priority picker with inputs req vector and base pointer, outputs grant index and valid; parameterised by NUM_CH.

Test Plan:
- Only ch1 eligible, LEVEL=3, TX_READY=1 -> stream 0x42, d0, d1, d2. Exactly 3 RDEN pulses on ch1, BUSY low after the last byte.
- ch0 LEVEL=40, BURST_MAX=16 -> header 0x0F and 16 bytes. Ch0 is re-granted only after other eligible channels have been served.
- All 4 channels eligible with LEVEL=1 -> headers in order ch0, ch1, ch2, ch3 (0x00, 0x40, 0x80, 0xC0), then wrap to ch0 if it is still eligible.
- TX_READY held low 10 cycles during HDR and again during DATA -> TX_VALID and TX_DATA stable throughout, no extra RDEN.
- FIFO_EMPTY forced high in RD for 5 cycles -> RDEN stays 0, FSM stalls, then resumes; byte count unchanged.
- RESETn low mid-payload -> next cycle all outputs at reset values. After release, ch0 wins first if eligible.
